// File: rtl/program_counter.sv
// Fetch-address register: holds PC, advances it by STEP, loads branch targets,
// and produces the registered fetch-valid and pipeline-flush strobes.
module program_counter #(
  parameter int unsigned           WIDTH        = 16,
  parameter logic [WIDTH-1:0]      RESET_VECTOR = '0,
  parameter int unsigned           STEP         = 1
) (
  input  logic             CLK,
  input  logic             R_,
  input  logic             STALL,
  input  logic             BR,
  input  logic [WIDTH-1:0] TARGET,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC_INC,
  output logic             VALID,
  output logic             FLUSH
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             valid_q, valid_d;
  logic             flush_q, flush_d;

  // Carry out of the MSB falls off the WIDTH-bit result, giving mod 2^WIDTH wrap.
  assign PC_INC = pc_q + STEP_W;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    flush_d = 1'b0;

    unique case (state_q)
      BOOT: begin
        // First edge out of reset presents the reset vector; branch/stall ignored.
        state_d = RUN;
        pc_d    = RESET_VECTOR;
        valid_d = 1'b1;
      end
      RUN: begin
        valid_d = 1'b1;
        if (BR) begin
          pc_d    = TARGET;
          flush_d = 1'b1;
        end else if (!STALL) begin
          pc_d = PC_INC;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge R_) begin
    if (!R_) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      flush_q <= flush_d;
    end
  end

  assign PC    = pc_q;
  assign VALID = valid_q;
  assign FLUSH = flush_q;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: an edge-level reference model checked
// every falling clock edge, plus directed vectors with hand-computed values.
module tb_program_counter;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned STEP  = 1;
  localparam int unsigned MODV  = 65536;
  localparam logic [15:0] RV    = 16'h0000;

  logic        CLK = 1'b0;
  logic        R_  = 1'b1;
  logic        STALL = 1'b0;
  logic        BR    = 1'b0;
  logic [15:0] TARGET = 16'h0000;
  logic [15:0] PC, PC_INC;
  logic        VALID, FLUSH;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  program_counter #(
    .WIDTH(WIDTH),
    .RESET_VECTOR(RV),
    .STEP(STEP)
  ) dut (
    .CLK(CLK),
    .R_(R_),
    .STALL(STALL),
    .BR(BR),
    .TARGET(TARGET),
    .PC(PC),
    .PC_INC(PC_INC),
    .VALID(VALID),
    .FLUSH(FLUSH)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: edges since reset decide behaviour; the first edge only
  // presents the reset vector, later edges follow branch > stall > increment.
  int unsigned m_pc      = RV;
  bit          m_valid   = 1'b0;
  bit          m_flush   = 1'b0;
  int unsigned m_edges   = 0;

  always @(posedge CLK or negedge R_) begin
    if (!R_) begin
      m_pc    = RV;
      m_valid = 1'b0;
      m_flush = 1'b0;
      m_edges = 0;
    end else begin
      if (m_edges == 0) begin
        m_pc    = RV;
        m_flush = 1'b0;
      end else begin
        m_flush = BR;
        if (BR)          m_pc = TARGET;
        else if (!STALL) m_pc = (m_pc + STEP) % MODV;
      end
      m_valid = 1'b1;
      m_edges++;
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      check("model_pc",     PC,     m_pc);
      check("model_pc_inc", PC_INC, (m_pc + STEP) % MODV);
      check("model_valid",  VALID,  m_valid);
      check("model_flush",  FLUSH,  m_flush);
    end
  end

  task automatic edge_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [15:0] pc, input logic valid,
                            input logic flush);
    check({name, "_pc"},    PC,    pc);
    check({name, "_valid"}, VALID, valid);
    check({name, "_flush"}, FLUSH, flush);
  endtask

  task automatic boot_sequence(input string tag);
    BR = 1'b1; TARGET = 16'h1234; STALL = 1'b0;
    for (int i = 0; i < 3; i++) begin
      edge_step();
      expect_out({tag, "_in_reset"}, 16'h0000, 1'b0, 1'b0);
    end
    R_ = 1'b1;
    edge_step();
    expect_out({tag, "_edge1"}, 16'h0000, 1'b1, 1'b0);
    BR = 1'b0;
    edge_step();
    expect_out({tag, "_edge2"}, 16'h0001, 1'b1, 1'b0);
  endtask

  initial begin
    #1 R_ = 1'b0;
    cmp_en = 1'b1;
    #1;
    expect_out("por", 16'h0000, 1'b0, 1'b0);
    check("por_pc_inc", PC_INC, 16'h0001);

    boot_sequence("boot");

    // Wrap at the top of the address space.
    BR = 1'b1; TARGET = 16'hFFFE;
    edge_step();
    expect_out("wrap_load", 16'hFFFE, 1'b1, 1'b1);
    BR = 1'b0;
    edge_step();
    expect_out("wrap_ffff", 16'hFFFF, 1'b1, 1'b0);
    check("wrap_pc_inc", PC_INC, 16'h0000);
    edge_step();
    expect_out("wrap_0000", 16'h0000, 1'b1, 1'b0);
    edge_step();
    expect_out("wrap_0001", 16'h0001, 1'b1, 1'b0);

    // Stall holds PC with VALID kept high.
    BR = 1'b1; TARGET = 16'h0010;
    edge_step();
    BR = 1'b0; STALL = 1'b1;
    for (int i = 0; i < 4; i++) begin
      edge_step();
      expect_out("stall_hold", 16'h0010, 1'b1, 1'b0);
    end
    STALL = 1'b0;
    edge_step();
    expect_out("stall_release", 16'h0011, 1'b1, 1'b0);

    // Single branch pulse gives a one-cycle flush.
    BR = 1'b1; TARGET = 16'h001F;
    edge_step();
    BR = 1'b0;
    edge_step();
    expect_out("br_start", 16'h0020, 1'b1, 1'b0);
    BR = 1'b1; TARGET = 16'h0100;
    edge_step();
    expect_out("br_taken", 16'h0100, 1'b1, 1'b1);
    BR = 1'b0;
    edge_step();
    expect_out("br_after", 16'h0101, 1'b1, 1'b0);

    // Branches win over stall, back-to-back.
    STALL = 1'b1; BR = 1'b1; TARGET = 16'h0200;
    edge_step();
    expect_out("bb_first", 16'h0200, 1'b1, 1'b1);
    TARGET = 16'h0300;
    edge_step();
    expect_out("bb_second", 16'h0300, 1'b1, 1'b1);
    BR = 1'b0;
    edge_step();
    expect_out("bb_hold1", 16'h0300, 1'b1, 1'b0);
    edge_step();
    expect_out("bb_hold2", 16'h0300, 1'b1, 1'b0);

    // Branch to the current PC acts like a stall with flush.
    BR = 1'b1; TARGET = 16'h0300;
    edge_step();
    expect_out("self_br", 16'h0300, 1'b1, 1'b1);

    // Reset between edges while a branch flush is showing.
    STALL = 1'b0; BR = 1'b1; TARGET = 16'h0400;
    edge_step();
    expect_out("mid_br", 16'h0400, 1'b1, 1'b1);
    #2 R_ = 1'b0;
    #1;
    expect_out("mid_reset", 16'h0000, 1'b0, 1'b0);
    check("mid_reset_pc_inc", PC_INC, 16'h0001);

    boot_sequence("reboot");

    edge_step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
